// File: rtl/riio_gpi_rx_filter_if.sv
// Pad-receiver control/status bundle: core-side controls in, filtered level, pulses and edge count out.
// The master drives the controls and the raw pad level; the filter is the slave.
interface riio_gpi_rx_filter_if #(
    parameter int CNT_W = 8,
    parameter int EC_W  = 16
);
    logic             di;
    logic             ie;
    logic             filt_en;
    logic [CNT_W-1:0] filt_cnt;
    logic             clr;
    logic             lvl;
    logic             rise;
    logic             fall;
    logic             glitch;
    logic [EC_W-1:0]  edge_cnt;

    modport master (
        output di, ie, filt_en, filt_cnt, clr,
        input  lvl, rise, fall, glitch, edge_cnt
    );

    modport slave (
        input  di, ie, filt_en, filt_cnt, clr,
        output lvl, rise, fall, glitch, edge_cnt
    );
endinterface

// File: rtl/riio_gpi_rx_filter.sv
// GPI pad receiver: synchronises the raw pad level, qualifies transitions over a programmable
// number of cycles, and reports the filtered level, edge/glitch pulses and a saturating edge count.
module riio_gpi_rx_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 8,
    parameter int   EC_W        = 16,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    riio_gpi_rx_filter_if.slave bus
);

    typedef enum logic {STABLE, QUALIFY} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0]       neff;
    logic                   qualified;
    logic                   accept;
    logic                   lvl, lvl_nxt;
    logic                   rise, rise_nxt;
    logic                   fall, fall_nxt;
    logic                   glitch, glitch_nxt;
    logic [EC_W-1:0]        edge_cnt, edge_cnt_nxt;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A zero threshold or a disabled filter both degrade to single-cycle acceptance.
    assign neff      = (!bus.filt_en || bus.filt_cnt == '0) ? CNT_W'(1) : bus.filt_cnt;
    assign qualified = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, neff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else if (bus.ie) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.di};
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        lvl_nxt      = lvl;
        rise_nxt     = 1'b0;
        fall_nxt     = 1'b0;
        glitch_nxt   = 1'b0;
        accept       = 1'b0;
        edge_cnt_nxt = edge_cnt;

        if (!bus.ie) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                STABLE: begin
                    cnt_nxt = '0;
                    if (sync_s != lvl) begin
                        if (neff == CNT_W'(1)) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = QUALIFY;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (sync_s == lvl) begin
                        state_nxt  = STABLE;
                        cnt_nxt    = '0;
                        glitch_nxt = 1'b1;
                    end else if (qualified) begin
                        accept    = 1'b1;
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        if (accept) begin
            lvl_nxt  = sync_s;
            rise_nxt = sync_s;
            fall_nxt = !sync_s;
        end

        // Clear wins over the stored count but not over an edge accepted in the same cycle.
        if (bus.clr) begin
            edge_cnt_nxt = accept ? EC_W'(1) : '0;
        end else if (accept && edge_cnt != '1) begin
            edge_cnt_nxt = edge_cnt + EC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STABLE;
            cnt      <= '0;
            lvl      <= RST_VAL;
            rise     <= 1'b0;
            fall     <= 1'b0;
            glitch   <= 1'b0;
            edge_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lvl      <= lvl_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
            glitch   <= glitch_nxt;
            edge_cnt <= edge_cnt_nxt;
        end
    end

    assign bus.lvl      = lvl;
    assign bus.rise     = rise;
    assign bus.fall     = fall;
    assign bus.glitch   = glitch;
    assign bus.edge_cnt = edge_cnt;

endmodule

// File: tb/tb_riio_gpi_rx_filter.sv
// Bench for the GPI receiver filter: directed scenarios plus a randomized phase, every cycle
// compared against a run-length reference model of the qualification rules.
module tb_riio_gpi_rx_filter;

    localparam int   SS    = 2;
    localparam int   CNT_W = 8;
    localparam int   EC_W  = 4;
    localparam logic RV    = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    riio_gpi_rx_filter_if #(.CNT_W(CNT_W), .EC_W(EC_W)) bus ();

    riio_gpi_rx_filter #(
        .SYNC_STAGES(SS),
        .CNT_W      (CNT_W),
        .EC_W       (EC_W),
        .RST_VAL    (RV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pad history as a delay queue, pending transition as a run length.
    logic m_sync[$];
    logic m_lvl, m_rise, m_fall, m_glitch;
    int   m_run, m_cnt;

    int n_rise, n_fall, n_glitch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = {};
        for (int i = 0; i < SS; i++) m_sync.push_back(RV);
        m_lvl    = RV;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 1'b0;
        m_run    = 0;
        m_cnt    = 0;
    endtask

    task automatic model_step();
        int   neff;
        logic s;
        bit   acc;
        neff     = (!bus.filt_en || bus.filt_cnt == 0) ? 1 : int'(bus.filt_cnt);
        s        = m_sync[SS-1];
        acc      = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_glitch = 1'b0;
        if (bus.ie) begin
            if (s !== m_lvl) begin
                if (m_run + 1 >= neff) begin
                    acc    = 1'b1;
                    m_lvl  = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run  = 0;
                end else begin
                    m_run++;
                end
            end else begin
                m_glitch = (m_run > 0);
                m_run    = 0;
            end
            m_sync.push_front(bus.di);
            void'(m_sync.pop_back());
        end else begin
            m_run = 0;
        end
        if (bus.clr)                                  m_cnt = acc ? 1 : 0;
        else if (acc && m_cnt < (1 << EC_W) - 1)      m_cnt++;
    endtask

    task automatic compare_outputs();
        check("lvl",      bus.lvl,      m_lvl);
        check("rise",     bus.rise,     m_rise);
        check("fall",     bus.fall,     m_fall);
        check("glitch",   bus.glitch,   m_glitch);
        check("edge_cnt", bus.edge_cnt, m_cnt);
        check("rise_fall_excl", bus.rise & bus.fall, 0);
        n_rise   += int'(bus.rise);
        n_fall   += int'(bus.fall);
        n_glitch += int'(bus.glitch);
    endtask

    task automatic cyc();
        if (rst_n) model_step();
        else       model_reset();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic clear_tallies();
        n_rise   = 0;
        n_fall   = 0;
        n_glitch = 0;
    endtask

    initial begin
        logic held;

        bus.di       = 1'b1;
        bus.ie       = 1'b1;
        bus.filt_en  = 1'b0;
        bus.filt_cnt = '0;
        bus.clr      = 1'b0;
        model_reset();
        clear_tallies();

        // 1: pad high through reset, bypass mode; release and watch the first rise.
        repeat (3) cyc();
        check("t1_no_pulse_in_reset", n_rise + n_fall + n_glitch, 0);
        rst_n = 1'b1;
        cyc(); check("t1_e1_lvl", bus.lvl, 0);
        cyc(); check("t1_e2_lvl", bus.lvl, 0);
        cyc(); check("t1_e3_lvl", bus.lvl, 1);
        check("t1_e3_rise", bus.rise, 1);
        check("t1_e3_cnt", bus.edge_cnt, 1);
        cyc(); check("t1_rise_one_cycle", bus.rise, 0);

        // 2: qualification over 4 cycles, both directions, then a short glitch.
        bus.filt_en  = 1'b1;
        bus.filt_cnt = CNT_W'(4);
        bus.di       = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i < 6) check("t2_fall_hold", bus.lvl, 1);
        end
        check("t2_fall_lvl", bus.lvl, 0);
        check("t2_fall_pulse", bus.fall, 1);
        bus.di = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i < 6) check("t2_rise_hold", bus.lvl, 0);
        end
        check("t2_rise_lvl", bus.lvl, 1);
        check("t2_rise_pulse", bus.rise, 1);
        check("t2_cnt", bus.edge_cnt, 3);
        clear_tallies();
        bus.di = 1'b0;
        repeat (3) cyc();
        bus.di = 1'b1;
        repeat (8) cyc();
        check("t2_glitch_once", n_glitch, 1);
        check("t2_glitch_no_edge", n_rise + n_fall, 0);
        check("t2_glitch_lvl", bus.lvl, 1);
        check("t2_glitch_cnt", bus.edge_cnt, 3);

        // 3: zero threshold behaves as bypass; 10 toggles two cycles apart.
        bus.clr = 1'b1;
        cyc();
        check("t3_clr", bus.edge_cnt, 0);
        bus.clr      = 1'b0;
        bus.filt_cnt = '0;
        clear_tallies();
        for (int t = 0; t < 10; t++) begin
            bus.di = !bus.di;
            cyc();
            cyc();
        end
        repeat (3) cyc();
        check("t3_rises", n_rise, 5);
        check("t3_falls", n_fall, 5);
        check("t3_cnt", bus.edge_cnt, 10);

        // 4: counter saturation, then a clear coincident with an accepted edge.
        for (int t = 0; t < 20; t++) begin
            bus.di = !bus.di;
            cyc();
            cyc();
        end
        repeat (3) cyc();
        check("t4_saturate", bus.edge_cnt, 15);
        bus.di = !bus.di;
        cyc();
        cyc();
        bus.clr = 1'b1;
        cyc();
        check("t4_clr_edge_pulse", bus.rise | bus.fall, 1);
        check("t4_clr_with_edge", bus.edge_cnt, 1);
        bus.clr = 1'b0;
        cyc();

        // 5: receiver frozen while the pad toggles, then a changed level after re-enable.
        bus.di = m_lvl;
        repeat (4) cyc();
        held   = m_lvl;
        bus.ie = 1'b0;
        clear_tallies();
        repeat (50) begin
            bus.di = 1'($urandom_range(0, 1));
            cyc();
        end
        check("t5_no_pulses", n_rise + n_fall + n_glitch, 0);
        check("t5_lvl_held", bus.lvl, held);
        check("t5_cnt_held", bus.edge_cnt, 1);
        bus.filt_cnt = CNT_W'(3);
        bus.di       = !held;
        bus.ie       = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i < 5) check("t5_resume_hold", bus.lvl, held);
        end
        check("t5_resume_lvl", bus.lvl, !held);

        // 6: reset asserted mid-qualification with the level high.
        bus.filt_cnt = CNT_W'(4);
        bus.di       = 1'b1;
        repeat (8) cyc();
        check("t6_pre_lvl", bus.lvl, 1);
        bus.di = 1'b0;
        repeat (4) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_async_lvl", bus.lvl, 0);
        check("t6_async_cnt", bus.edge_cnt, 0);
        check("t6_async_pulses", {bus.rise, bus.fall, bus.glitch}, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        clear_tallies();
        repeat (10) cyc();
        check("t6_quiet_after_release", n_rise + n_fall + n_glitch, 0);
        bus.di = 1'b1;
        repeat (2) cyc();
        bus.di = 1'b0;
        repeat (8) cyc();
        check("t6_short_glitch", n_glitch, 1);
        check("t6_no_edge", n_rise + n_fall, 0);
        check("t6_lvl", bus.lvl, 0);

        // Randomized phase: pad activity, threshold changes, enable gaps and clears.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0)  bus.di = !bus.di;
            if ($urandom_range(0, 23) == 0) bus.filt_cnt = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) bus.filt_en = !bus.filt_en;
            bus.ie  = ($urandom_range(0, 15) != 0);
            bus.clr = ($urandom_range(0, 31) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
